shape_reg_bank: RTL and testbench
=================================

# shape_reg_bank

Parametrised, double-buffered register bank that captures vertex/shape words from the SRAM integration datapath into NUM_CH channels of DATA_W bits. Writes land in a staging (shadow) bank, either by explicit channel select or by an auto-incrementing write pointer. A commit copies the whole shadow bank atomically into the active bank that drives the drawing logic, so downstream never sees a half-updated shape.

## Interface
- DATA_W, 16: width of each channel word.
- NUM_CH, 4: number of channels; 2..16, need not be a power of two.
- SEL_W, $clog2(NUM_CH): select/pointer width.
- AUTO_COMMIT, 0: 1 = commit automatically when the auto pointer wraps.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write strobe, one word per cycle.
- data_in  in  DATA_W  write data.
- sel  in  SEL_W  target channel when auto_inc=0.
- auto_inc  in  1  1 = ignore sel and write to the internal pointer.
- commit  in  1  copy shadow to active (one-cycle strobe).
- v_flat  out  NUM_CH*DATA_W  active bank; channel k occupies bits [k*DATA_W +: DATA_W].
- wr_ptr  out  SEL_W  current auto pointer.
- loaded_mask  out  NUM_CH  shadow channels written since the last commit.
- frame_done  out  1  one-cycle pulse when the auto pointer wraps.
- sel_err  out  1  one-cycle pulse when a write to sel >= NUM_CH is dropped.

## Operation
- Reset (synchronous, active-high) clears the shadow bank, v_flat, wr_ptr, loaded_mask, frame_done and sel_err to 0. Reset has priority over every other input. A reset mid-frame discards the staged data.
- Manual write (wr_en=1, auto_inc=0):
  - sel < NUM_CH: shadow[sel] <= data_in and loaded_mask[sel] <= 1. wr_ptr is unchanged.
  - sel >= NUM_CH: the write is dropped and sel_err pulses. No state changes.
- Auto write (wr_en=1, auto_inc=1):
  - shadow[wr_ptr] <= data_in and loaded_mask[wr_ptr] <= 1.
  - wr_ptr increments. At NUM_CH-1 it wraps to 0 and frame_done pulses.
  - sel is ignored and sel_err never fires.
- Commit (commit=1, or AUTO_COMMIT=1 together with an auto write at wr_ptr=NUM_CH-1):
  - v_flat <= shadow, including any write in the same cycle (the same-cycle write passes through to active).
  - loaded_mask <= 0 and wr_ptr <= 0.
  - The shadow bank keeps its contents.
- A commit while wr_en=0 copies shadow unchanged. Repeated commits are idempotent.
- A manual write while wr_ptr != 0 is legal and does not disturb the pointer. Mixing modes within a frame is allowed.
- Channels not written are held. v_flat changes only on commit or reset.

## Timing
- Write-to-shadow latency is 1 cycle. Shadow contents are not visible on any port except through loaded_mask.
- Commit-to-output latency: v_flat shows the new values in the cycle after the commit edge.
- A write and a commit in the same cycle: v_flat shows the written word 1 cycle later.
- frame_done and sel_err are registered and are high for exactly the cycle following the triggering edge.
- With AUTO_COMMIT=1, frame_done and the v_flat update appear in the same cycle.
- Throughput is one word per cycle with no stall; there is no backpressure output.

## Structure
- Shared package `shape_pkg`:
  - default DATA_W and NUM_CH localparams.
  - a `ch_slice(k)` width helper or function for indexing v_flat.
- One sub-module, `shape_wr_ptr`: a wrapping counter with inc, clear and wrap-pulse outputs, parametrised by NUM_CH.
- The bank and the mask stay in the top module, using generate loops over NUM_CH.

## Test plan
- Reset then manual loads: write 0x1111/0x2222/0x3333/0x4444 to sel 0..3 and check that v_flat is still 0. Pulse commit and check that v_flat = {0x4444,0x3333,0x2222,0x1111} one cycle later and loaded_mask goes from 0xF to 0.
- Auto mode, NUM_CH=4, AUTO_COMMIT=1: four writes 0xA0..0xA3 must give frame_done and a v_flat update in the cycle after the 4th write, with wr_ptr=0.
- Same-cycle write and commit: write sel=2, data 0xBEEF with commit=1. Check v_flat ch2 = 0xBEEF next cycle and loaded_mask = 0.
- NUM_CH=3, write to sel=3: check that sel_err pulses for 1 cycle and the shadow, mask and v_flat are unchanged.
- Reset mid-frame: after 2 auto writes, assert reset, then commit. Check that v_flat = 0, wr_ptr = 0 and loaded_mask = 0.
- Hold check: commit with wr_en=0 twice in a row leaves v_flat identical, and channels never written keep their prior committed values.

Source files
------------

// File: rtl/shape_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shape_pkg
// Description : Shared defaults and channel-slice helper for shape_reg_bank.
// Revision    : 1.0 - initial release
// ============================================================================
package shape_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 4;

    // Low bit of channel k inside a flat bus of w-bit channels.
    function automatic int ch_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shape_wr_ptr.sv
`default_nettype none
// ============================================================================
// Module      : shape_wr_ptr
// Description : Wrapping 0..NUM_CH-1 write pointer with clear and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module shape_wr_ptr #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [SEL_W-1:0] o_ptr,
    output logic             o_wrap
);

    localparam logic [SEL_W-1:0] C_LAST = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0] r_ptr;

    // Combinational so the top can commit in the same edge as the wrap.
    assign o_wrap = i_inc && (r_ptr == C_LAST);
    assign o_ptr  = r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clr || o_wrap) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shape_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : shape_reg_bank
// Description : Double-buffered shape register bank; shadow writes, atomic
//               commit to the active bank driving v_flat.
// Revision    : 1.0 - initial release
// ============================================================================
module shape_reg_bank
    import shape_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SEL_W       = $clog2(NUM_CH),
    parameter int AUTO_COMMIT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     auto_inc,
    input  logic                     commit,
    output logic [NUM_CH*DATA_W-1:0] v_flat,
    output logic [SEL_W-1:0]         wr_ptr,
    output logic [NUM_CH-1:0]        loaded_mask,
    output logic                     frame_done,
    output logic                     sel_err
);

    localparam logic [SEL_W:0] C_NUM_CH = (SEL_W + 1)'(NUM_CH);

    logic [DATA_W-1:0] r_shadow [NUM_CH];
    logic [DATA_W-1:0] r_active [NUM_CH];
    logic [DATA_W-1:0] w_sh_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] w_hit;
    logic              r_frame_done;
    logic              r_sel_err;

    logic              w_auto_wr;
    logic              w_sel_ok;
    logic              w_man_wr;
    logic              w_sel_bad;
    logic              w_wrap;
    logic              w_commit;
    logic [SEL_W-1:0]  w_ptr;
    logic [SEL_W-1:0]  w_idx;

    assign w_auto_wr = wr_en && auto_inc;
    assign w_sel_ok  = ({1'b0, sel} < C_NUM_CH);
    assign w_man_wr  = wr_en && !auto_inc && w_sel_ok;
    assign w_sel_bad = wr_en && !auto_inc && !w_sel_ok;
    assign w_idx     = auto_inc ? w_ptr : sel;
    assign w_commit  = commit || ((AUTO_COMMIT != 0) && w_wrap);

    shape_wr_ptr #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_wr_ptr (
        .clk    (clk),
        .rst    (reset),
        .i_inc  (w_auto_wr),
        .i_clr  (w_commit),
        .o_ptr  (w_ptr),
        .o_wrap (w_wrap)
    );

    // Next-shadow values feed the active bank so a same-cycle write commits.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_hit[k]    = (w_auto_wr || w_man_wr) && (w_idx == SEL_W'(k));
        assign w_sh_nxt[k] = w_hit[k] ? data_in : r_shadow[k];
        assign v_flat[ch_lo(k, DATA_W) +: DATA_W] = r_active[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_mask       <= '0;
            r_frame_done <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            r_sel_err    <= w_sel_bad;
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= w_sh_nxt[k];
            end
            if (w_commit) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_active[k] <= w_sh_nxt[k];
                end
                r_mask <= '0;
            end else begin
                r_mask <= r_mask | w_hit;
            end
        end
    end

    assign wr_ptr      = w_ptr;
    assign loaded_mask = r_mask;
    assign frame_done  = r_frame_done;
    assign sel_err     = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_shape_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_shape_reg_bank
// Description : Directed plus random checks of two shape_reg_bank configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shape_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 channels, auto commit. Instance B: 3 channels, manual commit.
    logic        a_rst, a_we, a_ai, a_cm;
    logic [15:0] a_d;
    logic [1:0]  a_sel;
    logic [63:0] a_vf;
    logic [1:0]  a_ptr;
    logic [3:0]  a_mask;
    logic        a_fd, a_se;

    logic        b_rst, b_we, b_ai, b_cm;
    logic [15:0] b_d;
    logic [1:0]  b_sel;
    logic [47:0] b_vf;
    logic [1:0]  b_ptr;
    logic [2:0]  b_mask;
    logic        b_fd, b_se;

    shape_reg_bank #(.DATA_W(16), .NUM_CH(4), .AUTO_COMMIT(1)) u_a (
        .clk(clk), .reset(a_rst), .wr_en(a_we), .data_in(a_d), .sel(a_sel),
        .auto_inc(a_ai), .commit(a_cm), .v_flat(a_vf), .wr_ptr(a_ptr),
        .loaded_mask(a_mask), .frame_done(a_fd), .sel_err(a_se)
    );

    shape_reg_bank #(.DATA_W(16), .NUM_CH(3), .AUTO_COMMIT(0)) u_b (
        .clk(clk), .reset(b_rst), .wr_en(b_we), .data_in(b_d), .sel(b_sel),
        .auto_inc(b_ai), .commit(b_cm), .v_flat(b_vf), .wr_ptr(b_ptr),
        .loaded_mask(b_mask), .frame_done(b_fd), .sel_err(b_se)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, index 0 = A, 1 = B.
    logic [15:0] m_sh  [2][16];
    logic [15:0] m_act [2][16];
    int          m_ptr [2];
    int          m_mask[2];
    int          m_fd  [2];
    int          m_se  [2];

    task automatic model_step(input int id, input int nch, input int ac,
                              input logic rst, input logic we, input logic [15:0] d,
                              input int s, input logic ai, input logic cm);
        int  idx;
        bit  wrote, wrapped;
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_sh[id][k]  = 16'h0;
                m_act[id][k] = 16'h0;
            end
            m_ptr[id] = 0; m_mask[id] = 0; m_fd[id] = 0; m_se[id] = 0;
            return;
        end
        wrote = 0; wrapped = 0; idx = 0;
        m_fd[id] = 0; m_se[id] = 0;
        if (we) begin
            if (ai) begin
                idx = m_ptr[id]; wrote = 1;
                m_ptr[id] = (m_ptr[id] + 1) % nch;
                if (m_ptr[id] == 0) begin
                    wrapped = 1; m_fd[id] = 1;
                end
            end else if (s < nch) begin
                idx = s; wrote = 1;
            end else begin
                m_se[id] = 1;
            end
        end
        if (wrote) begin
            m_sh[id][idx] = d;
            m_mask[id] = m_mask[id] | (1 << idx);
        end
        if (cm || (ac != 0 && wrapped)) begin
            for (int k = 0; k < nch; k++) m_act[id][k] = m_sh[id][k];
            m_mask[id] = 0; m_ptr[id] = 0;
        end
    endtask

    function automatic logic [63:0] exp_vf(input int id, input int nch);
        logic [63:0] r;
        r = 64'h0;
        for (int k = 0; k < nch; k++) r[k*16 +: 16] = m_act[id][k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("a_vflat", a_vf, exp_vf(0, 4));
        chk("a_ptr",   64'(a_ptr),  64'(m_ptr[0]));
        chk("a_mask",  64'(a_mask), 64'(m_mask[0]));
        chk("a_fd",    64'(a_fd),   64'(m_fd[0]));
        chk("a_se",    64'(a_se),   64'(m_se[0]));
        chk("b_vflat", 64'(b_vf),   exp_vf(1, 3));
        chk("b_ptr",   64'(b_ptr),  64'(m_ptr[1]));
        chk("b_mask",  64'(b_mask), 64'(m_mask[1]));
        chk("b_fd",    64'(b_fd),   64'(m_fd[1]));
        chk("b_se",    64'(b_se),   64'(m_se[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4, 1, a_rst, a_we, a_d, int'(a_sel), a_ai, a_cm);
        model_step(1, 3, 0, b_rst, b_we, b_d, int'(b_sel), b_ai, b_cm);
        #1;
        check_model();
    endtask

    task automatic idle();
        a_rst = 0; a_we = 0; a_ai = 0; a_cm = 0; a_d = '0; a_sel = '0;
        b_rst = 0; b_we = 0; b_ai = 0; b_cm = 0; b_d = '0; b_sel = '0;
    endtask

    initial begin
        idle();
        a_rst = 1; b_rst = 1;
        tick(); tick();
        idle();
        chk("reset_vflat", a_vf, 64'h0);
        chk("reset_mask", 64'(a_mask), 64'h0);

        // Manual loads, then commit.
        for (int i = 0; i < 4; i++) begin
            a_we = 1; a_sel = 2'(i); a_d = 16'h1111 * 16'(i + 1);
            tick();
        end
        idle();
        chk("man_vflat_precommit", a_vf, 64'h0);
        chk("man_mask_full", 64'(a_mask), 64'hF);
        a_cm = 1; tick(); idle();
        chk("man_vflat_commit", a_vf, 64'h4444_3333_2222_1111);
        chk("man_mask_clear", 64'(a_mask), 64'h0);

        // Auto mode with auto commit on the 4th write.
        for (int i = 0; i < 4; i++) begin
            a_we = 1; a_ai = 1; a_d = 16'hA0 + 16'(i);
            tick();
        end
        idle();
        chk("auto_fd", 64'(a_fd), 64'h1);
        chk("auto_vflat", a_vf, 64'h00A3_00A2_00A1_00A0);
        chk("auto_ptr", 64'(a_ptr), 64'h0);
        tick();
        chk("auto_fd_drop", 64'(a_fd), 64'h0);

        // Same-cycle write and commit.
        a_we = 1; a_sel = 2'd2; a_d = 16'hBEEF; a_cm = 1;
        tick(); idle();
        chk("wc_ch2", 64'(a_vf[47:32]), 64'hBEEF);
        chk("wc_mask", 64'(a_mask), 64'h0);

        // Out-of-range select on the 3-channel bank.
        b_we = 1; b_sel = 2'd1; b_d = 16'h7777; tick(); idle();
        b_we = 1; b_sel = 2'd3; b_d = 16'hDEAD; tick(); idle();
        chk("selerr_pulse", 64'(b_se), 64'h1);
        chk("selerr_mask", 64'(b_mask), 64'h2);
        chk("selerr_vflat", 64'(b_vf), 64'h0);
        tick();
        chk("selerr_drop", 64'(b_se), 64'h0);
        b_cm = 1; tick(); idle();
        chk("selerr_shadow", 64'(b_vf), 64'h0000_7777_0000);

        // Reset mid-frame discards staged data.
        a_we = 1; a_ai = 1; a_d = 16'h5555; tick(); tick();
        idle(); a_rst = 1; tick(); idle();
        a_cm = 1; tick(); idle();
        chk("rstmid_vflat", a_vf, 64'h0);
        chk("rstmid_ptr", 64'(a_ptr), 64'h0);
        chk("rstmid_mask", 64'(a_mask), 64'h0);

        // Hold: repeated commits with no writes are idempotent.
        a_we = 1; a_sel = 2'd1; a_d = 16'h5A5A; a_cm = 1; tick(); idle();
        a_we = 1; a_sel = 2'd0; a_d = 16'h1234; tick(); idle();
        chk("hold_nocommit", a_vf, 64'h0000_0000_5A5A_0000);
        a_cm = 1; tick();
        chk("hold_commit1", a_vf, 64'h0000_0000_5A5A_1234);
        tick(); idle();
        chk("hold_commit2", a_vf, 64'h0000_0000_5A5A_1234);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            a_rst = ($urandom_range(0, 59) == 0);
            a_we  = ($urandom_range(0, 3) != 0);
            a_ai  = $urandom_range(0, 1) == 1;
            a_cm  = ($urandom_range(0, 6) == 0);
            a_d   = 16'($urandom);
            a_sel = 2'($urandom_range(0, 3));
            b_rst = ($urandom_range(0, 59) == 0);
            b_we  = ($urandom_range(0, 3) != 0);
            b_ai  = $urandom_range(0, 1) == 1;
            b_cm  = ($urandom_range(0, 6) == 0);
            b_d   = 16'($urandom);
            b_sel = 2'($urandom_range(0, 3));
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
